// File: rtl/iob_pkg.sv
// iob_pkg: shared types and constants for the IOB scheduler.
package iob_pkg;
  localparam int IOB_AW = 23;
  localparam int IOB_GAP_CYCLES = 1;
  typedef enum logic [1:0] {C_IDLE, C_DIRQ, C_DIRW} cpu_state_t;
  typedef enum logic [1:0] {B_IDLE, B_POST, B_DIR, B_GAP} bus_state_t;
  typedef struct packed {
    logic [IOB_AW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } iob_entry_t;
endpackage

// File: rtl/iob_pwq.sv
// iob_pwq: circular posted-write queue; a pop and push in one cycle keep the count.
module iob_pwq #(
  parameter int DEPTH = 4,
  parameter int W = 41
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign head = mem[rp];
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= din;
    if (RES) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/iob_sched.sv
// iob_sched: sequences FSB accesses onto the IOB; postable writes are acked at once
// and drained in order, direct accesses wait until no posted write is queued or in flight.
module iob_sched import iob_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = IOB_AW
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          BACT,
  input  logic          IOCS,
  input  logic          IOPWCS,
  input  logic          nWE,
  input  logic [AW-1:0] A,
  input  logic [15:0]   DI,
  input  logic [1:0]    BE,
  output logic          FSBDone,
  output logic          IOREQ,
  output logic          IOWE,
  output logic [AW-1:0] IOA,
  output logic [15:0]   IOD,
  output logic [1:0]    IOBE,
  input  logic          IOACK,
  output logic          QEmpty,
  output logic          QFull
);
  localparam int W = AW + 18;
  cpu_state_t cs, cs_n;
  bus_state_t bs, bs_n;
  logic accepted, push, pop, dir_go, dir_done;
  logic [W-1:0] head;
  iob_pwq #(.DEPTH(DEPTH), .W(W)) u_pwq (
    .CLK(CLK), .RES(RES), .push(push), .pop(pop), .din({A, DI, BE}),
    .head(head), .full(QFull), .empty(QEmpty)
  );
  // A full queue still accepts in the cycle its head retires.
  always_comb begin
    pop = bs == B_POST && IOACK;
    push = cs == C_IDLE && BACT && IOPWCS && !accepted && (!QFull || pop);
    dir_go = cs == C_DIRQ && BACT && QEmpty && bs == B_IDLE;
    dir_done = cs == C_DIRW && bs == B_DIR && IOACK;
    IOREQ = bs == B_POST || bs == B_DIR;
    cs_n = (cs == C_IDLE && BACT && IOCS && !IOPWCS && !accepted) ? C_DIRQ :
           (cs == C_DIRQ && !BACT) ? C_IDLE :
           dir_go ? C_DIRW :
           dir_done ? C_IDLE : cs;
    bs_n = (bs == B_IDLE) ? (!QEmpty ? B_POST : dir_go ? B_DIR : B_IDLE) :
           (bs == B_GAP) ? B_IDLE :
           IOACK ? B_GAP : bs;
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      cs <= C_IDLE;
      bs <= B_IDLE;
      accepted <= 1'b0;
      FSBDone <= 1'b0;
      {IOWE, IOA, IOD, IOBE} <= '0;
    end else begin
      cs <= cs_n;
      bs <= bs_n;
      accepted <= BACT && (accepted || push || dir_done);
      FSBDone <= push || dir_done;
      if (bs == B_IDLE && !QEmpty) {IOWE, IOA, IOD, IOBE} <= {1'b1, head};
      else if (dir_go) {IOWE, IOA, IOD, IOBE} <= {~nWE, A, DI, BE};
    end
  end
endmodule

// File: doc/iob_sched.md
Name: iob_sched

Overview:
- Single-clock controller that sequences FSB accesses onto the slow I/O bus (IOB).
- Owns a small posted-write queue. Low-RAM writes (IOPWCS) are acknowledged to the CPU at once and mirrored to the IOB in the background. Non-posted I/O accesses (IOCS) go out directly to the IOB.
- Sits between the chip-select decode (source of IOCS/IOPWCS/BACT) and the IOB bus engine (IOREQ/IOACK handshake).
- Guarantees IOB program order and single ownership of the IOB.

Parameters:
- DEPTH, 4, posted-write queue entries; power of two, >=2.
- AW, 23, address width (word address A[23:1]).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RES  in  1  synchronous reset, active-high.
- BACT  in  1  FSB cycle active; high from address strobe to cycle end.
- IOCS  in  1  decoded I/O-space select, valid while BACT.
- IOPWCS  in  1  decoded postable write (low RAM, write), valid while BACT.
- nWE  in  1  FSB write strobe, active-low.
- A  in  AW  FSB word address.
- DI  in  16  FSB write data.
- BE  in  2  byte enables {upper, lower}, active-high.
- FSBDone  out  1  one-cycle acknowledge to FSB cycle terminator.
- IOREQ  out  1  IOB request, level.
- IOWE  out  1  IOB write (1) / read (0).
- IOA  out  AW  IOB address.
- IOD  out  16  IOB write data.
- IOBE  out  2  IOB byte enables.
- IOACK  in  1  IOB completion pulse, 1 cycle.
- QEmpty  out  1  posted-write queue empty.
- QFull  out  1  posted-write queue full.

Behaviour:
- Reset (RES high at an edge): queue pointers/count cleared; both FSMs to idle; FSBDone=0, IOREQ=0, IOWE=0, IOA=0, IOD=0, IOBE=0, QEmpty=1, QFull=0. Takes effect at that edge even mid-IOB transfer; any IOACK in the first cycle after reset is ignored.
- Accepted flag: set when an FSB cycle is acknowledged, cleared when BACT=0. A cycle is never serviced twice.
- CPU-side FSM:
  - C_IDLE:
    - BACT & IOPWCS & ~accepted & ~QFull -> enqueue {A,DI,BE}; FSBDone=1 the next cycle. Latency 1.
    - If QFull -> stay; enqueue in the first cycle QFull=0, including the cycle a drain completes.
    - BACT & IOCS & ~IOPWCS & ~accepted -> C_DIRQ.
    - IOPWCS takes precedence if both are asserted.
  - C_DIRQ: wait for QEmpty & bus FSM in B_IDLE, then hand request to bus FSM -> C_DIRW.
  - C_DIRW: on IOACK of the direct cycle, FSBDone=1 next cycle -> C_IDLE.
  - If BACT drops in C_DIRQ before issue -> return to C_IDLE, nothing issued.
- Bus-side FSM:
  - B_IDLE:
    - Queue non-empty -> load head into IOA/IOD/IOBE, IOWE=1, IOREQ=1 -> B_POST.
    - Else direct request pending -> load A/DI/BE, IOWE=~nWE, IOREQ=1 -> B_DIR.
    - Queue drain always wins.
  - B_POST: hold outputs stable; on IOACK -> dequeue, IOREQ=0 -> B_GAP.
  - B_DIR: hold outputs stable; on IOACK -> IOREQ=0, notify CPU FSM -> B_GAP.
  - B_GAP: one cycle with IOREQ=0 (min idle between IOB requests) -> B_IDLE.
- Queue:
  - Circular, pointers modulo DEPTH; count width log2(DEPTH)+1.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - QFull = count==DEPTH; QEmpty = count==0; both registered-accurate the cycle after the change.
- Ordering: a direct read/write never reaches the IOB while any posted write is queued or in flight.
- IOACK while IOREQ=0 is ignored.

Decomposition:
- Shared package iob_pkg: state enums for both FSMs, entry typedef {addr[AW-1:0], data[15:0], be[1:0]}, constant IOB_GAP_CYCLES=1.
- One sub-module: iob_pwq (parameterized DEPTH circular queue: push/pop/head/full/empty).

Test Plan:
- Single posted write A=0x1F8000, DI=0xBEEF, BE=2'b11 -> FSBDone one cycle after BACT; IOREQ rises in B_IDLE with IOA=0x1F8000, IOD=0xBEEF, IOWE=1; QEmpty=1 after IOACK.
- Five back-to-back posted writes with IOACK withheld -> 4 acknowledged, QFull=1, 5th FSBDone delayed until first IOACK; IOB issue order matches enqueue order.
- Posted write then IOCS read A=0x7FFFF0 -> read IOREQ only after the write's IOACK plus 1 gap cycle, IOWE=0; FSBDone one cycle after read IOACK.
- Enqueue in the same cycle as dequeue at QFull (count 4) -> count stays 4, no entry lost or duplicated.
- RES asserted while IOREQ=1 in B_POST with 3 queued -> next cycle IOREQ=0, QEmpty=1, FSBDone=0; a following IOACK has no effect.
- BACT held high after FSBDone for 3 extra cycles -> exactly one enqueue, one FSBDone pulse.
